// File: rtl/apb2axi_fifo_mc.sv
// rtl/apb2axi_fifo_mc.sv - multi-channel FIFO over one shared RAM with round-robin read port.
// Optional high-water-mark output ch_hwm enabled by defining APB2AXI_FIFO_MC_HWM_EN.
module apb2axi_fifo_mc #(
  parameter int WIDTH    = 32,
  parameter int CH_NUM   = 4,
  parameter int CH_DEPTH = 8,
  parameter int AFULL_TH = 6,
  localparam int CHW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
  localparam int LW  = $clog2(CH_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  input  logic [CHW-1:0]       wr_ch,
  input  logic [WIDTH-1:0]     wr_data,
  output logic                 wr_ready,
  input  logic [CH_NUM-1:0]    flush,
  output logic                 rd_valid,
  output logic [CHW-1:0]       rd_ch,
  output logic [WIDTH-1:0]     rd_data,
  input  logic                 rd_ready,
  output logic [CH_NUM*LW-1:0] ch_level,
  output logic [CH_NUM-1:0]    ch_full,
  output logic [CH_NUM-1:0]    ch_afull,
  output logic [CH_NUM-1:0]    ch_empty
`ifdef APB2AXI_FIFO_MC_HWM_EN
  ,
  output logic [CH_NUM*LW-1:0] ch_hwm
`endif
);

  localparam int AW = CHW + LW - 1;
  localparam int NW = CH_NUM * CH_DEPTH;

  logic [WIDTH-1:0]            mem_q [NW];
  logic [CH_NUM-1:0][LW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d, level;
  logic                        rd_valid_q, rd_valid_d;
  logic [CHW-1:0]              rd_ch_q, rd_ch_d, rr_q, rr_d, grant;
  logic [WIDTH-1:0]            rd_data_q, rd_data_d;
  logic [CH_NUM-1:0]           elig;
  logic [AW-1:0]               wr_addr, rd_addr;
  logic                        push, load, any_elig;
  int                          arb_idx;

  always_comb begin
    level    = '0;
    ch_level = '0;
    ch_full  = '0;
    ch_afull = '0;
    ch_empty = '0;
    elig     = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      level[c]              = wptr_q[c] - rptr_q[c];
      ch_level[c*LW +: LW]  = level[c];
      ch_full[c]            = (level[c] == LW'(CH_DEPTH));
      ch_afull[c]           = (level[c] >= LW'(AFULL_TH));
      ch_empty[c]           = (level[c] == '0);
      elig[c]               = !ch_empty[c] && !flush[c];
    end
  end

  // wr_ready is decoded per channel so an out-of-range wr_ch simply reads as not ready
  always_comb begin
    wr_ready = 1'b0;
    wr_addr  = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      if (wr_ch == CHW'(c)) begin
        wr_ready = !ch_full[c] && !flush[c];
        wr_addr  = {CHW'(c), wptr_q[c][LW-2:0]};
      end
    end
    push = wr_valid && wr_ready;
  end

  always_comb begin
    any_elig = 1'b0;
    grant    = '0;
    arb_idx  = 0;
    for (int i = 0; i < CH_NUM; i++) begin
      arb_idx = (int'(rr_q) + i) % CH_NUM;
      if (!any_elig && elig[arb_idx]) begin
        any_elig = 1'b1;
        grant    = CHW'(arb_idx);
      end
    end
    rd_addr = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      if (grant == CHW'(c)) rd_addr = {grant, rptr_q[c][LW-2:0]};
    end
    load = (!rd_valid_q || rd_ready) && any_elig;
  end

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    rd_valid_d = rd_valid_q;
    rd_ch_d    = rd_ch_q;
    rd_data_d  = rd_data_q;
    rr_d       = rr_q;
    for (int c = 0; c < CH_NUM; c++) begin
      if (push && wr_ch == CHW'(c)) wptr_d[c] = wptr_q[c] + LW'(1);
      if (flush[c])                 rptr_d[c] = wptr_q[c];
      else if (load && grant == CHW'(c)) rptr_d[c] = rptr_q[c] + LW'(1);
    end
    if (load) begin
      rd_valid_d = 1'b1;
      rd_ch_d    = grant;
      rd_data_d  = mem_q[rd_addr];
      rr_d       = (grant == CHW'(CH_NUM - 1)) ? '0 : grant + CHW'(1);
    end else if (rd_ready) begin
      rd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_ch_q    <= '0;
      rd_data_q  <= '0;
      rr_q       <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      rd_valid_q <= rd_valid_d;
      rd_ch_q    <= rd_ch_d;
      rd_data_q  <= rd_data_d;
      rr_q       <= rr_d;
    end
  end

  // storage is deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_addr] <= wr_data;
  end

  assign rd_valid = rd_valid_q;
  assign rd_ch    = rd_ch_q;
  assign rd_data  = rd_data_q;

`ifdef APB2AXI_FIFO_MC_HWM_EN
  logic [CH_NUM-1:0][LW-1:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d  = hwm_q;
    ch_hwm = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      if (flush[c])                  hwm_d[c] = '0;
      else if (level[c] > hwm_q[c])  hwm_d[c] = level[c];
      ch_hwm[c*LW +: LW] = hwm_q[c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) hwm_q <= '0;
    else     hwm_q <= hwm_d;
  end
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !wr_ready));
      if (wr_valid) assert (32'(wr_ch) < CH_NUM);
      for (int c = 0; c < CH_NUM; c++) assert (level[c] <= LW'(CH_DEPTH));
    end
  end
`endif

endmodule

// File: tb/tb_apb2axi_fifo_mc.sv
// tb/tb_apb2axi_fifo_mc.sv - randomized bench for apb2axi_fifo_mc against a queue-based model.
// Checks ch_hwm as well when APB2AXI_FIFO_MC_HWM_EN is defined.
module tb_apb2axi_fifo_mc;
  localparam int N = 4, D = 8, AF = 6, LW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_valid = 1'b0;
  logic [1:0]      wr_ch = '0;
  logic [31:0]     wr_data = '0;
  logic            wr_ready;
  logic [N-1:0]    flush = '0;
  logic            rd_valid;
  logic [1:0]      rd_ch;
  logic [31:0]     rd_data;
  logic            rd_ready = 1'b0;
  logic [N*LW-1:0] ch_level;
  logic [N-1:0]    ch_full, ch_afull, ch_empty;
`ifdef APB2AXI_FIFO_MC_HWM_EN
  logic [N*LW-1:0] ch_hwm;
`endif

  always #5 clk = ~clk;

  apb2axi_fifo_mc #(.WIDTH(32), .CH_NUM(N), .CH_DEPTH(D), .AFULL_TH(AF)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ch(wr_ch), .wr_data(wr_data), .wr_ready(wr_ready),
    .flush(flush),
    .rd_valid(rd_valid), .rd_ch(rd_ch), .rd_data(rd_data), .rd_ready(rd_ready),
    .ch_level(ch_level), .ch_full(ch_full), .ch_afull(ch_afull), .ch_empty(ch_empty)
`ifdef APB2AXI_FIFO_MC_HWM_EN
    , .ch_hwm(ch_hwm)
`endif
  );

  logic [31:0] mq [N][$];
  bit          ov;
  int          och, rrm;
  logic [31:0] od;
  int          hwm [N];
  int          checks = 0, errors = 0;
  bit          chk_en = 0;
  int          hs_ch[$];
  int          n_acc1 = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input int ch, input logic [31:0] d, input logic [N-1:0] fl, input bit rdy);
    bit acc;
    bit found;
    int g;
    int lvl_pre [N];
    logic [N*LW-1:0] e_lvl, e_hwm;
    logic [N-1:0] e_full, e_afull, e_empty;
    wr_valid = v;
    wr_ch    = 2'(ch);
    wr_data  = d;
    flush    = fl;
    rd_ready = rdy;
    #1;
    acc = 0;
    if (!rst) begin
      acc = v && (mq[ch].size() < D) && !fl[ch];
      if (chk_en) begin
        check("wr_ready", wr_ready, (mq[ch].size() < D) && !fl[ch]);
        if (rd_valid && rdy) hs_ch.push_back(int'(rd_ch));
      end
    end
    @(posedge clk);
    if (rst) begin
      for (int c = 0; c < N; c++) begin
        mq[c].delete();
        hwm[c] = 0;
      end
      ov = 0; och = 0; od = '0; rrm = 0;
    end else begin
      for (int c = 0; c < N; c++) lvl_pre[c] = mq[c].size();
      if (!ov || rdy) begin
        found = 0;
        g = 0;
        for (int i = 0; i < N; i++) begin
          int c;
          c = (rrm + i) % N;
          if (!found && mq[c].size() > 0 && !fl[c]) begin
            found = 1;
            g = c;
          end
        end
        if (found) begin
          od  = mq[g].pop_front();
          och = g;
          ov  = 1;
          rrm = (g + 1) % N;
        end else if (rdy) begin
          ov = 0;
        end
      end
      for (int c = 0; c < N; c++) if (fl[c]) mq[c].delete();
      if (acc) begin
        mq[ch].push_back(d);
        if (ch == 1) n_acc1++;
      end
      for (int c = 0; c < N; c++) hwm[c] = fl[c] ? 0 : ((lvl_pre[c] > hwm[c]) ? lvl_pre[c] : hwm[c]);
    end
    #1;
    if (chk_en && !rst) begin
      check("rd_valid", rd_valid, ov);
      if (ov) begin
        check("rd_ch", rd_ch, och);
        check("rd_data", rd_data, od);
      end
      e_lvl = '0; e_hwm = '0;
      for (int c = 0; c < N; c++) begin
        e_lvl[c*LW +: LW] = LW'(mq[c].size());
        e_hwm[c*LW +: LW] = LW'(hwm[c]);
        e_full[c]  = (mq[c].size() == D);
        e_afull[c] = (mq[c].size() >= AF);
        e_empty[c] = (mq[c].size() == 0);
      end
      check("ch_level", ch_level, e_lvl);
      check("ch_full", ch_full, e_full);
      check("ch_afull", ch_afull, e_afull);
      check("ch_empty", ch_empty, e_empty);
`ifdef APB2AXI_FIFO_MC_HWM_EN
      check("ch_hwm", ch_hwm, e_hwm);
`endif
    end
  endtask

  initial begin
    int exp_seq [8];
    int cnt;
    exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3};

    rst = 1'b1;
    repeat (3) step(0, 0, '0, '0, 0);
    rst = 1'b0;
    chk_en = 1;
    repeat (5) step(0, 0, '0, '0, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_empty", ch_empty, 4'hF);
    check("rst_level", ch_level, 0);
    check("rst_wr_ready", wr_ready, 1);

    step(1, 2, 32'hA5A5_0001, '0, 1);
    step(0, 0, '0, '0, 1);
    check("lat_valid", rd_valid, 1);
    check("lat_ch", rd_ch, 2);
    check("lat_data", rd_data, 32'hA5A5_0001);
    check("lat_lvl2", ch_level[11:8], 0);
    step(0, 0, '0, '0, 1);

    for (int i = 0; i < 9; i++) step(1, 0, 32'h3000_0000 + 32'(i), '0, 0);
    check("full0", ch_full[0], 1);
    check("afull0", ch_afull[0], 1);
    check("full_wr_ready", wr_ready, 0);
    hs_ch.delete();
    repeat (10) step(0, 0, '0, '0, 1);
    check("drain_cnt", hs_ch.size(), 9);

    for (int c = 0; c < N; c++)
      for (int k = 0; k < 2; k++) step(1, c, 32'h4000_0000 + 32'(c * 16 + k), '0, 0);
    hs_ch.delete();
    repeat (10) step(0, 0, '0, '0, 1);
    check("rr_cnt", hs_ch.size(), 8);
    for (int i = 0; i < 8; i++) check("rr_seq", (hs_ch.size() > i) ? hs_ch[i] : -1, exp_seq[i]);
    step(1, 1, 32'h5000_0001, '0, 1);
    hs_ch.delete();
    repeat (3) step(0, 0, '0, '0, 1);
    check("rr_single", (hs_ch.size() > 0) ? hs_ch[0] : -1, 1);

    for (int k = 0; k < 6; k++) step(1, 3, 32'h6000_0000 + 32'(k), '0, 0);
    check("fl_pre_lvl", ch_level[15:12], 5);
    step(1, 3, 32'h6000_00FF, 4'b1000, 0);
    check("fl_lvl3", ch_level[15:12], 0);
    check("fl_out_valid", rd_valid, 1);
    check("fl_out_ch", rd_ch, 3);
    hs_ch.delete();
    repeat (2) step(0, 0, '0, '0, 1);
    check("fl_delivered", hs_ch.size(), 1);

    hs_ch.delete();
    n_acc1 = 0;
    repeat (9) step(1, 1, $urandom, '0, 0);
    repeat (100) step($urandom_range(0, 3) != 0, 1, $urandom, '0, $urandom_range(0, 3) != 0);
    repeat (12) step(0, 1, '0, '0, 1);
    cnt = 0;
    foreach (hs_ch[i]) if (hs_ch[i] == 1) cnt++;
    check("ch1_conserve", cnt, n_acc1);
    check("ch1_wraps", n_acc1 >= 3 * 2 * D, 1);
`ifdef APB2AXI_FIFO_MC_HWM_EN
    check("hwm1", ch_hwm[7:4], 8);
`endif

    repeat (300) begin
      logic [N-1:0] fl;
      fl = ($urandom_range(0, 15) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
      step($urandom_range(0, 1), $urandom_range(0, N - 1), $urandom, fl, $urandom_range(0, 2) != 0);
    end

    rst = 1'b1;
    step(1, 2, 32'hDEAD_BEEF, '0, 0);
    rst = 1'b0;
    repeat (4) step(0, 0, '0, '0, 1);
    check("mid_rst_empty", ch_empty, 4'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
